// File: rtl/fir_inv_pkg.sv
// Shared types, default parameters and coefficient helper for fir_inverse_dec.
// The optional saturating MAC is enabled by defining FIR_INV_SAT_EN.
package fir_inv_pkg;

  localparam int DW_DEF       = 32;
  localparam int CW_DEF       = 16;
  localparam int N_TAPS_DEF   = 10;
  localparam int H0_SHIFT_DEF = 7;

  // {h9..h1}, h1 in the LSBs: h1 = -64, all others zero
  localparam logic [(N_TAPS_DEF-1)*CW_DEF-1:0] COEFFS_DEF = {128'd0, 16'hFFC0};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2,
    HOLD = 2'd3
  } state_e;

  function automatic logic signed [CW_DEF-1:0] coeff_at(
    input logic [(N_TAPS_DEF-1)*CW_DEF-1:0] coeffs,
    input int                               k
  );
    return coeffs[(k-1)*CW_DEF +: CW_DEF];
  endfunction

endpackage

// File: rtl/fir_inv_mac.sv
// Combinational multiply-subtract step: acc - trunc_DW(h * x).
// With FIR_INV_SAT_EN defined the subtraction saturates and reports a clip.
module fir_inv_mac #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic signed [DW-1:0] acc_i,
  input  logic signed [CW-1:0] coeff_i,
  input  logic signed [DW-1:0] hist_i,
  output logic signed [DW-1:0] acc_o
`ifdef FIR_INV_SAT_EN
  ,
  output logic                 clip_o
`endif
);

  // Low DW bits of the product do not depend on how far it is extended.
  logic signed [DW-1:0] prod_t;
  assign prod_t = DW'(coeff_i) * hist_i;

`ifdef FIR_INV_SAT_EN
  logic [DW:0] diff;
  assign diff = {acc_i[DW-1], acc_i} - {prod_t[DW-1], prod_t};

  always_comb begin
    clip_o = diff[DW] ^ diff[DW-1];
    if (!clip_o)       acc_o = diff[DW-1:0];
    else if (diff[DW]) acc_o = {1'b1, {(DW-1){1'b0}}};
    else               acc_o = {1'b0, {(DW-1){1'b1}}};
  end
`else
  assign acc_o = acc_i - prod_t;
`endif

endmodule

// File: rtl/fir_inverse_dec.sv
// All-pole inverse of a 10-tap FIR: one time-multiplexed MAC, one sample per pass.
// Optional saturating arithmetic and sticky sat_flag under FIR_INV_SAT_EN.
module fir_inverse_dec
  import fir_inv_pkg::*;
#(
  parameter int                        DW       = DW_DEF,
  parameter int                        CW       = CW_DEF,
  parameter int                        N_TAPS   = N_TAPS_DEF,
  parameter int                        H0_SHIFT = H0_SHIFT_DEF,
  parameter logic [(N_TAPS-1)*CW-1:0]  COEFFS   = COEFFS_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
`ifdef FIR_INV_SAT_EN
  output logic          sat_flag,
`endif
  output logic [1:0]    dbg_state
);

  localparam int KW = $clog2(N_TAPS + 1);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_MAC  = MAC;
  localparam logic [1:0] S_OUT  = OUT;
  localparam logic [1:0] S_HOLD = HOLD;

  logic [1:0]           state_q, state_d;
  logic signed [DW-1:0] acc_q, acc_d;
  logic [KW-1:0]        k_q, k_d;
  logic                 out_valid_q, out_valid_d;
  logic [DW-1:0]        out_data_q, out_data_d;
  logic signed [DW-1:0] hist_q [1:N_TAPS-1];
  logic signed [DW-1:0] hist_d [1:N_TAPS-1];
  logic signed [CW-1:0] h_arr  [1:N_TAPS-1];
  logic signed [CW-1:0] coeff_sel;
  logic signed [DW-1:0] hist_sel;
  logic signed [DW-1:0] mac_acc;
  logic signed [DW-1:0] x_new;

  for (genvar g = 1; g < N_TAPS; g++) begin : g_coeff
    assign h_arr[g] = COEFFS[(g-1)*CW +: CW];
  end

  always_comb begin
    coeff_sel = '0;
    hist_sel  = '0;
    for (int i = 1; i < N_TAPS; i++) begin
      if (k_q == KW'(i)) begin
        coeff_sel = h_arr[i];
        hist_sel  = hist_q[i];
      end
    end
  end

`ifdef FIR_INV_SAT_EN
  logic mac_clip;
  logic sat_q, sat_d;

  fir_inv_mac #(.DW(DW), .CW(CW)) u_mac (
    .acc_i   (acc_q),
    .coeff_i (coeff_sel),
    .hist_i  (hist_sel),
    .acc_o   (mac_acc),
    .clip_o  (mac_clip)
  );
`else
  fir_inv_mac #(.DW(DW), .CW(CW)) u_mac (
    .acc_i   (acc_q),
    .coeff_i (coeff_sel),
    .hist_i  (hist_sel),
    .acc_o   (mac_acc)
  );
`endif

  assign x_new = acc_q >>> H0_SHIFT;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    hist_d      = hist_q;
`ifdef FIR_INV_SAT_EN
    sat_d       = sat_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          acc_d   = in_data;
          k_d     = KW'(1);
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = mac_acc;
        k_d   = k_q + KW'(1);
`ifdef FIR_INV_SAT_EN
        sat_d = sat_q | mac_clip;
`endif
        if (k_q == KW'(N_TAPS-1)) state_d = S_OUT;
      end
      S_OUT: begin
        out_data_d  = x_new;
        out_valid_d = 1'b1;
        hist_d[1]   = x_new;
        for (int i = 2; i < N_TAPS; i++) hist_d[i] = hist_q[i-1];
        k_d         = '0;
        state_d     = S_HOLD;
      end
      default: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 1; i < N_TAPS; i++) hist_q[i] <= '0;
`ifdef FIR_INV_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      for (int i = 1; i < N_TAPS; i++) hist_q[i] <= hist_d[i];
`ifdef FIR_INV_SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // in_ready depends only on registered state, never on out_ready.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign dbg_state = state_q;
`ifdef FIR_INV_SAT_EN
  assign sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_fir_inverse_dec.sv
// Bench for fir_inverse_dec: directed vector table, multi-cycle corner sequences
// and randomized samples checked against a recurrence-level reference model.
module tb_fir_inverse_dec;
  import fir_inv_pkg::*;

  localparam int DW = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [1:0]    dbg_state;
`ifdef FIR_INV_SAT_EN
  logic          sat_flag;
`endif

  typedef struct {
    logic [DW-1:0] y;
    logic [DW-1:0] x;
  } vec_t;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];
  logic signed [DW-1:0] m_hist [1:9];
`ifdef FIR_INV_SAT_EN
  bit m_sat;
`endif

  fir_inverse_dec dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef FIR_INV_SAT_EN
    .sat_flag  (sat_flag),
`endif
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // reference model: x[n] = (y[n] - sum h[k]*x[n-k]) >>> 7, step by step mod 2^32
  task automatic ref_sub(inout logic signed [DW-1:0] acc, input logic signed [15:0] h,
                         input logic signed [DW-1:0] x);
    longint p;
    longint d;
    logic signed [DW-1:0] pt;
    p  = longint'(h) * longint'(x);
    pt = p[31:0];
    d  = longint'(acc) - longint'(pt);
`ifdef FIR_INV_SAT_EN
    if (d > SMAX) begin
      acc = SMAX[31:0];
      m_sat = 1'b1;
    end else if (d < SMIN) begin
      acc = SMIN[31:0];
      m_sat = 1'b1;
    end else begin
      acc = d[31:0];
    end
`else
    acc = d[31:0];
`endif
  endtask

  task automatic model_reset();
    for (int i = 1; i <= 9; i++) m_hist[i] = '0;
`ifdef FIR_INV_SAT_EN
    m_sat = 1'b0;
`endif
  endtask

  task automatic model_step(input logic [DW-1:0] y, output logic [DW-1:0] x);
    logic signed [DW-1:0] acc;
    acc = y;
    for (int k = 1; k <= 9; k++) ref_sub(acc, coeff_at(COEFFS_DEF, k), m_hist[k]);
    x = acc >>> 7;
    for (int k = 9; k > 1; k--) m_hist[k] = m_hist[k-1];
    m_hist[1] = x;
  endtask

  // drivers
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_state", dbg_state, IDLE);
  endtask

  task automatic send(input logic [DW-1:0] y);
    int n;
    n = 0;
    while (!in_ready && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_data = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(input string nm, input int stall);
    int n;
    logic [DW-1:0] e;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!out_valid && n < 40);
    check({nm, "_lat"}, n, 10);
    e = exp_q.pop_front();
    check({nm, "_x"}, out_data, e);
`ifdef FIR_INV_SAT_EN
    check({nm, "_sat"}, sat_flag, m_sat);
`endif
    if (stall > 0) begin
      repeat (stall) begin
        @(posedge clk);
        #1;
      end
      check({nm, "_hold"}, {out_valid, in_ready, out_data}, {1'b1, 1'b0, e});
      out_ready = 1'b1;
    end
  endtask

  task automatic run(input logic [DW-1:0] y, input logic [DW-1:0] exp, input bit use_model,
                     input int stall, input string nm);
    logic [DW-1:0] m;
    model_step(y, m);
    exp_q.push_back(use_model ? m : exp);
    send(y);
    if (stall > 0) out_ready = 1'b0;
    collect(nm, stall);
  endtask

  initial begin
    vec_t vecs[6];
    logic [DW-1:0] m;
    logic [DW-1:0] y;
    bit seen;

    vecs[0] = '{32'd128,        32'd1};
    vecs[1] = '{32'hFFFF_FFC0,  32'd0};
    vecs[2] = '{32'd0,          32'd0};
    vecs[3] = '{32'd256,        32'd2};
    vecs[4] = '{32'd0,          32'd1};
    vecs[5] = '{32'd0,          32'd0};

    do_reset();
    for (int i = 0; i < 6; i++) run(vecs[i].y, vecs[i].x, 1'b0, 0, $sformatf("vec%0d", i));

    // backpressure: result held, new sample offered but not taken
    do_reset();
    model_step(32'd256, m);
    exp_q.push_back(32'd2);
    send(32'd256);
    out_ready = 1'b0;
    collect("bp_first", 0);
    in_valid = 1'b1;
    in_data = 32'd0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d", i), {out_valid, in_ready, out_data}, {1'b1, 1'b0, 32'd2});
    end
    check("bp_state", dbg_state, HOLD);
    out_ready = 1'b1;
    run(32'd0, 32'd1, 1'b0, 0, "bp_next");

    // reset in the middle of the MAC pass
    do_reset();
    send(32'd256);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("midrst_state", dbg_state, MAC);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_valid", seen, 0);
    run(32'd128, 32'd1, 1'b0, 0, "midrst_next");

    // accumulator overflow boundary
    do_reset();
    run(32'h7FFF_FFFF, 32'h00FF_FFFF, 1'b0, 0, "ovf0");
`ifdef FIR_INV_SAT_EN
    check("sat_flag0", sat_flag, 0);
    run(32'h7FFF_FFFF, 32'h00FF_FFFF, 1'b0, 0, "ovf1");
    check("sat_flag1", sat_flag, 1);
    run(32'd0, 32'h007F_FFFF, 1'b0, 0, "ovf2");
    check("sat_sticky", sat_flag, 1);
`else
    run(32'h7FFF_FFFF, 32'hFF7F_FFFF, 1'b0, 0, "ovf1");
`endif

    // randomized samples against the model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) y = $urandom_range(0, 8192) - 32'd4096;
      else            y = $urandom;
      run(y, '0, 1'b1, $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
